elevator_plant: RTL and testbench
=================================

ELEVATOR_PLANT -- requirements
Module: elevator_plant

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 25_000_000, giving clock cycles per floor-to-floor segment; legal range 2..2^26.
REQ-002 SHALL have parameter NUM_FLOORS, default 4, fixed at 4.
REQ-003 SHALL have port CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port estado_motor  input  2  motor command: 00 stop, 01 down, 10 up, 11 fail.
REQ-006 SHALL have port SW  output  6  floor sensors; [3:0] one-hot floor 1..4 when the car is aligned with a floor, else 0; [5:4] always 0.
REQ-007 SHALL have port floor_idx  output  2  last floor passed or occupied, 0..3.
REQ-008 SHALL have port arrived  output  1  one-cycle pulse when the car becomes aligned with a floor.
REQ-009 SHALL have port fault  output  1  sticky fault flag.

Function
REQ-010 SHALL model car position pos in 0..3*TRAVEL_CYCLES; floor f aligned iff pos == f*TRAVEL_CYCLES.
REQ-011 SHALL sample estado_motor every rising edge; all outputs registered and reflect the pos value produced at that same edge.
REQ-012 SHALL use states AT_FLOOR, MOVE_UP, MOVE_DOWN, STALLED, FAULT.
REQ-013 SHALL, on command 10 with pos < 3*TRAVEL_CYCLES and no fault, increment pos by 1 at that edge.
REQ-014 SHALL, on command 01 with pos > 0 and no fault, decrement pos by 1 at that edge.
REQ-015 SHALL, on command 00, hold pos; between floors this is STALLED, SW[3:0] stays 0.
REQ-016 SHALL allow direction reversal on any cycle mid-segment with no extra latency; car returns toward the origin floor.
REQ-017 SHALL drive SW[3:0] = 0 whenever pos is not a floor multiple.
REQ-018 SHALL pulse arrived for exactly one cycle at the edge where pos becomes a floor multiple via motion; no pulse while holding at a floor.
REQ-019 SHALL update floor_idx to the new floor on arrival; unchanged while moving or stalled.
REQ-020 SHALL enter FAULT on: command 10 at pos == 3*TRAVEL_CYCLES (overrun top), command 01 at pos == 0 (overrun bottom), or command 11 in any state.
REQ-021 SHALL, in FAULT, freeze pos, SW and floor_idx, hold arrived = 0, set fault = 1, and ignore all commands until reset.
REQ-022 SHALL assert fault at the same edge the fault condition is sampled.
REQ-023 SHALL implement position as floor index plus segment offset counter (0..TRAVEL_CYCLES-1) with carry/borrow; no division or multiplication by TRAVEL_CYCLES.

Reset
REQ-024 SHALL, while reset_n = 0, force pos = 0, state AT_FLOOR, SW = 6'b000001, floor_idx = 0, arrived = 0, fault = 0, regardless of clock.
REQ-025 SHALL, on reset assertion mid-segment or in FAULT, abandon the segment and return immediately to the reset values.
REQ-026 SHALL resume sampling commands at the first rising edge after reset_n deasserts.

Structure
REQ-027 SHALL place motor command encodings (STOP 00, DOWN 01, UP 10, FAIL 11), NUM_FLOORS and the state enumeration in a shared package used also by the controller FSM.
REQ-028 SHALL contain one sub-module, segment_counter: up/down offset counter with terminal-count carry and zero borrow, parameterised by TRAVEL_CYCLES.

Verification (TRAVEL_CYCLES = 4)
REQ-029 SHALL check: reset_n low then high, command 00 -> SW = 000001, floor_idx = 0, arrived = 0, fault = 0.
REQ-030 SHALL check: command 10 for 4 cycles from floor 1 -> SW = 000000 for 3 cycles, then SW = 000010, floor_idx = 1, arrived = 1 for one cycle.
REQ-031 SHALL check: command 01 at floor 1 -> fault = 1 at that edge, SW stays 000001; subsequent 10 for 8 cycles leaves SW and floor_idx unchanged.
REQ-032 SHALL check: 10 for 2 cycles, 01 for 2 cycles -> SW = 000001 and arrived pulse on the 4th edge, floor_idx = 0.
REQ-033 SHALL check: 10 for 2 cycles, 00 for 5 cycles (SW = 000000 throughout), then 10 for 2 cycles -> SW = 000010, arrived pulse.
REQ-034 SHALL check: 10 for 6 cycles then reset_n low mid-segment -> SW = 000001, floor_idx = 0 without waiting for a clock edge; also command 11 at floor 3 -> fault = 1, SW frozen at 000100.

Source files
------------

// File: rtl/elevator_plant_pkg.sv
// -----------------------------------------------------------------------------
// elevator_plant_pkg
// Shared definitions for the elevator car plant model and its controller FSM:
//   - motor command encodings (STOP / DOWN / UP / FAIL)
//   - number of floors served by the shaft
//   - plant state enumeration
//   - helper that turns a floor index into the one-hot floor sensor vector
// -----------------------------------------------------------------------------
package elevator_plant_pkg;

    localparam int NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        CMD_STOP = 2'b00,
        CMD_DOWN = 2'b01,
        CMD_UP   = 2'b10,
        CMD_FAIL = 2'b11
    } motor_cmd_e;

    typedef enum logic [2:0] {
        AT_FLOOR  = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        STALLED   = 3'd3,
        FAULT     = 3'd4
    } plant_state_e;

    // Floor sensor vector: bit f set when the car is aligned with floor f.
    // The two upper bits are spare sensor inputs and always read 0.
    function automatic logic [5:0] floor_onehot(input logic [1:0] floor_idx);
        logic [5:0] sensors;
        sensors            = '0;
        sensors[floor_idx] = 1'b1;
        return sensors;
    endfunction

endpackage : elevator_plant_pkg

// File: rtl/elevator_plant_segment_counter.sv
// -----------------------------------------------------------------------------
// segment_counter
// Offset of the car inside the current floor-to-floor segment, 0..TRAVEL_CYCLES-1.
// Counting up past the last offset wraps to 0 and raises carry (car reached the
// next floor up); counting down from 0 wraps to TRAVEL_CYCLES-1 and raises
// borrow (car left its floor heading down).
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (offset -> 0)
//   up_i        advance one step upward this cycle
//   down_i      advance one step downward this cycle (never together with up_i)
//   at_zero_o   offset is 0, i.e. the car is aligned with a floor
//   carry_o     this step wraps the offset upward into the next segment
//   borrow_o    this step wraps the offset downward into the segment below
//   arrive_o    this step leaves the car aligned with a floor
// -----------------------------------------------------------------------------
module segment_counter #(
    parameter int TRAVEL_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic up_i,
    input  logic down_i,
    output logic at_zero_o,
    output logic carry_o,
    output logic borrow_o,
    output logic arrive_o
);

    localparam int               CNT_W = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] offset_q, offset_d;
    logic             at_last;

    assign at_last   = (offset_q == LAST);
    assign at_zero_o = (offset_q == '0);
    assign carry_o   = up_i   && at_last;
    assign borrow_o  = down_i && at_zero_o;
    // Downward arrival happens on the step from offset 1 to 0, upward arrival
    // on the wrap from the last offset to 0.
    assign arrive_o  = carry_o || (down_i && (offset_q == ONE));

    // NOTE: every signal driven from always_comb gets a default on entry so
    // that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        offset_d = offset_q;
        if (up_i) begin
            offset_d = at_last ? '0 : offset_q + ONE;
        end else if (down_i) begin
            offset_d = at_zero_o ? LAST : offset_q - ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

endmodule : segment_counter

// File: rtl/elevator_plant.sv
// -----------------------------------------------------------------------------
// elevator_plant
// Behavioural plant model of a four-floor elevator car driven by a motor
// command. Car position is kept as a floor index (floor at or below the car)
// plus a segment offset, so no multiplication or division by TRAVEL_CYCLES is
// needed. All outputs are registered and reflect the position produced at the
// same clock edge.
//
// Ports
//   CLOCK_50      system clock, rising edge
//   reset_n       asynchronous active-low reset; car returns to floor 1
//   estado_motor  motor command: 00 stop, 01 down, 10 up, 11 fail
//   SW            [3:0] one-hot floor sensors when aligned, else 0; [5:4] = 0
//   floor_idx     last floor passed or occupied, 0..3
//   arrived       one-cycle pulse when motion brings the car onto a floor
//   fault         sticky fault flag, cleared only by reset
// -----------------------------------------------------------------------------
module elevator_plant #(
    parameter int TRAVEL_CYCLES = 25_000_000,
    parameter int NUM_FLOORS    = elevator_plant_pkg::NUM_FLOORS
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [1:0] estado_motor,
    output logic [5:0] SW,
    output logic [1:0] floor_idx,
    output logic       arrived,
    output logic       fault
);

    import elevator_plant_pkg::*;

    localparam logic [1:0] TOP_FLOOR = 2'(NUM_FLOORS - 1);

    motor_cmd_e   cmd;
    plant_state_e state_q, state_d;
    logic [1:0]   base_q, base_d;        // floor at or below the car
    logic [5:0]   sw_q, sw_d;
    logic [1:0]   floor_idx_q, floor_idx_d;
    logic         arrived_q, arrived_d;
    logic         fault_q, fault_d;

    logic         in_fault;
    logic         at_zero, carry, borrow, arrive;
    logic         at_top, at_bottom;
    logic         up_en, down_en, fault_evt;
    logic [1:0]   arrive_floor;

    assign cmd = motor_cmd_e'(estado_motor);

    assign in_fault  = (state_q == FAULT);
    assign at_bottom = (base_q == 2'd0)      && at_zero;
    assign at_top    = (base_q == TOP_FLOOR) && at_zero;

    // Motion is only granted when it keeps the car inside the shaft; asking to
    // go past either end is a fault instead.
    assign up_en     = !in_fault && (cmd == CMD_UP)   && !at_top;
    assign down_en   = !in_fault && (cmd == CMD_DOWN) && !at_bottom;
    assign fault_evt = !in_fault && ((cmd == CMD_FAIL) ||
                                     ((cmd == CMD_UP)   && at_top) ||
                                     ((cmd == CMD_DOWN) && at_bottom));

    // Upward arrival crosses into the next floor; downward arrival lands on
    // the base floor itself.
    assign arrive_floor = carry ? base_q + 2'd1 : base_q;

    segment_counter #(
        .TRAVEL_CYCLES (TRAVEL_CYCLES)
    ) u_segment_counter (
        .clk_i     (CLOCK_50),
        .rst_ni    (reset_n),
        .up_i      (up_en),
        .down_i    (down_en),
        .at_zero_o (at_zero),
        .carry_o   (carry),
        .borrow_o  (borrow),
        .arrive_o  (arrive)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        sw_d        = sw_q;
        floor_idx_d = floor_idx_q;
        arrived_d   = 1'b0;
        fault_d     = fault_q;

        if (fault_evt) begin
            // Position, sensors and floor index freeze at their current values.
            state_d = FAULT;
            fault_d = 1'b1;
        end else if (up_en || down_en) begin
            if (carry) begin
                base_d = base_q + 2'd1;
            end else if (borrow) begin
                base_d = base_q - 2'd1;
            end
            if (arrive) begin
                state_d     = AT_FLOOR;
                sw_d        = floor_onehot(arrive_floor);
                floor_idx_d = arrive_floor;
                arrived_d   = 1'b1;
            end else begin
                state_d = up_en ? MOVE_UP : MOVE_DOWN;
                sw_d    = '0;
            end
        end else if (!in_fault) begin
            // Stop command (or nothing granted): hold position.
            state_d = at_zero ? AT_FLOOR : STALLED;
        end
    end

    // NOTE: all control and output registers are reset, including the sensor
    // vector, so the car reads as parked at floor 1 while reset is held.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= AT_FLOOR;
            base_q      <= 2'd0;
            sw_q        <= floor_onehot(2'd0);
            floor_idx_q <= 2'd0;
            arrived_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            sw_q        <= sw_d;
            floor_idx_q <= floor_idx_d;
            arrived_q   <= arrived_d;
            fault_q     <= fault_d;
        end
    end

    assign SW        = sw_q;
    assign floor_idx = floor_idx_q;
    assign arrived   = arrived_q;
    assign fault     = fault_q;

endmodule : elevator_plant

// File: tb/tb_elevator_plant.sv
// -----------------------------------------------------------------------------
// tb_elevator_plant
// Directed bench for elevator_plant with TRAVEL_CYCLES = 4. A position model
// (absolute position 0..12) computes the expected outputs for each command;
// expectations are queued when the command is driven and popped after the
// clock edge that should produce them.
// -----------------------------------------------------------------------------
module tb_elevator_plant;

    localparam int T   = 4;
    localparam int TOP = 3 * T;

    logic       CLOCK_50;
    logic       reset_n;
    logic [1:0] estado_motor;
    logic [5:0] SW;
    logic [1:0] floor_idx;
    logic       arrived;
    logic       fault;

    typedef struct {
        string      tag;
        logic [5:0] sw;
        logic [1:0] fidx;
        logic       arr;
        logic       flt;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int         m_pos;
    logic [1:0] m_fidx;
    logic       m_flt;

    elevator_plant #(
        .TRAVEL_CYCLES (T),
        .NUM_FLOORS    (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .estado_motor (estado_motor),
        .SW           (SW),
        .floor_idx    (floor_idx),
        .arrived      (arrived),
        .fault        (fault)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] model_sw();
        logic [5:0] s;
        s = '0;
        if ((m_pos % T) == 0) s[m_pos / T] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_fidx = 2'd0;
        m_flt  = 1'b0;
    endtask

    // Drive one command for one clock edge, then compare.
    task automatic step(input logic [1:0] cmd, input string tag);
        exp_t e;
        exp_t got;
        logic moved;
        @(negedge CLOCK_50);
        estado_motor = cmd;
        moved = 1'b0;
        if (!m_flt) begin
            case (cmd)
                2'b11: m_flt = 1'b1;
                2'b10: if (m_pos == TOP) m_flt = 1'b1; else begin m_pos++; moved = 1'b1; end
                2'b01: if (m_pos == 0)   m_flt = 1'b1; else begin m_pos--; moved = 1'b1; end
                default: ;
            endcase
        end
        e.tag  = tag;
        e.arr  = moved && ((m_pos % T) == 0);
        if (e.arr) m_fidx = 2'(m_pos / T);
        e.sw   = model_sw();
        e.fidx = m_fidx;
        e.flt  = m_flt;
        sb.push_back(e);

        @(posedge CLOCK_50);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({got.tag, "_SW"},        32'(SW),        32'(got.sw));
            check({got.tag, "_floor_idx"}, 32'(floor_idx), 32'(got.fidx));
            check({got.tag, "_arrived"},   32'(arrived),   32'(got.arr));
            check({got.tag, "_fault"},     32'(fault),     32'(got.flt));
        end
    endtask

    task automatic steps(input logic [1:0] cmd, input int n, input string tag);
        for (int i = 0; i < n; i++) step(cmd, tag);
    endtask

    // Assert reset away from any clock edge and check the outputs react
    // without waiting for a clock; release on the next falling edge.
    task automatic do_reset(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_rst_SW"},        32'(SW),        32'h01);
        check({tag, "_rst_floor_idx"}, 32'(floor_idx), 32'h0);
        check({tag, "_rst_arrived"},   32'(arrived),   32'h0);
        check({tag, "_rst_fault"},     32'(fault),     32'h0);
        @(negedge CLOCK_50);
        estado_motor = 2'b00;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        estado_motor = 2'b00;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        do_reset("init");

        // Idle at floor 1.
        steps(2'b00, 2, "idle");

        // Up one full segment: three unaligned cycles then arrival at floor 2.
        steps(2'b10, 4, "up_seg");
        // Hold at floor 2: no further arrival pulse.
        steps(2'b00, 2, "hold_f2");
        // Back down to floor 1.
        steps(2'b01, 4, "down_seg");

        // Bottom overrun faults immediately; later commands are ignored.
        step(2'b01, "ovr_bottom");
        steps(2'b10, 8, "in_fault");
        steps(2'b01, 2, "in_fault_dn");
        #1;
        do_reset("after_fault");

        // Reversal mid-segment returns to floor 1 with a pulse.
        steps(2'b10, 2, "rev_up");
        steps(2'b01, 2, "rev_down");

        // Stall mid-segment then continue to floor 2.
        steps(2'b10, 2, "stall_up");
        steps(2'b00, 5, "stalled");
        steps(2'b10, 2, "resume");

        // Reset while mid-segment.
        steps(2'b10, 6, "pre_rst");
        do_reset("mid_seg");

        // To floor 3, then explicit fail command freezes outputs.
        steps(2'b10, 8, "to_f3");
        step(2'b11, "cmd_fail");
        steps(2'b10, 3, "frozen_up");
        steps(2'b01, 3, "frozen_dn");
        do_reset("after_fail");

        // Full travel to floor 4 and top overrun.
        steps(2'b10, 12, "to_f4");
        step(2'b00, "hold_f4");
        step(2'b10, "ovr_top");
        steps(2'b01, 2, "top_frozen");
        do_reset("after_top");

        // Downward pass through a middle floor updates floor_idx on arrival.
        steps(2'b10, 8, "up_f3");
        steps(2'b01, 5, "down_mid");
        steps(2'b10, 1, "reverse_up");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_elevator_plant
